// File: rtl/am2910_ucode_pipe_if.sv
// am2910_ucode_pipe_if: bus between the am2910 sequencer and its control
// store / pipeline register.
// The optional parity signals exist only when AM2910_UCODE_PARITY_EN is defined.
interface am2910_ucode_pipe_if #(
   parameter int ABITS     = 12,
   parameter int DBITS     = 12,
   parameter int LOG_DEPTH = 6,
   parameter int CBITS     = 8
);
   // Sequencer-side address and condition inputs
   logic [ABITS-1:0]           Y;
   logic                       hold;
   logic [3:0]                 cond;

   // Control store write port
   logic                       wr_en;
   logic [LOG_DEPTH-1:0]       wr_addr;
   logic [16+DBITS+CBITS-9:0]  wr_data;

   // Pipeline register outputs
   logic [3:0]                 I;
   logic                       CCEN_BAR;
   logic                       CC_BAR;
   logic [DBITS-1:0]           D;
   logic [CBITS-1:0]           ctrl;
   logic                       valid;
   logic                       range_err;

`ifdef AM2910_UCODE_PARITY_EN
   logic                       wr_par_flip;
   logic                       par_err;

   modport master (
      output Y, hold, cond, wr_en, wr_addr, wr_data, wr_par_flip,
      input  I, CCEN_BAR, CC_BAR, D, ctrl, valid, range_err, par_err
   );
   modport slave (
      input  Y, hold, cond, wr_en, wr_addr, wr_data, wr_par_flip,
      output I, CCEN_BAR, CC_BAR, D, ctrl, valid, range_err, par_err
   );
`else
   modport master (
      output Y, hold, cond, wr_en, wr_addr, wr_data,
      input  I, CCEN_BAR, CC_BAR, D, ctrl, valid, range_err
   );
   modport slave (
      input  Y, hold, cond, wr_en, wr_addr, wr_data,
      output I, CCEN_BAR, CC_BAR, D, ctrl, valid, range_err
   );
`endif
endinterface

// File: rtl/am2910_ucode_pipe.sv
// am2910_ucode_pipe: writable microprogram control store plus pipeline
// register closing the am2910 fetch loop.
//
// Each un-held edge registers store[Y] into the pipeline register. Addresses
// beyond the store load a NOP (CONT, condition disabled) and set a sticky
// range_err. CC_BAR is derived only from registered state.
//
// Optional feature: define AM2910_UCODE_PARITY_EN to add an even-parity bit
// per store word, the wr_par_flip error-injection input and the sticky
// par_err output; a parity mismatch also loads the NOP word.
module am2910_ucode_pipe #(
   parameter int ABITS     = 12,
   parameter int DBITS     = 12,
   parameter int LOG_DEPTH = 6,
   parameter int CBITS     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   am2910_ucode_pipe_if.slave     bus
);

   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam int WBITS = 8 + DBITS + CBITS;
`ifdef AM2910_UCODE_PARITY_EN
   localparam int SBITS = WBITS + 1;
`else
   localparam int SBITS = WBITS;
`endif

   // Microword layout, MSB to LSB, matching the wr_data packing
   typedef struct packed {
      logic [3:0]       i;
      logic             ccen_bar;
      logic [1:0]       cc_sel;
      logic             cc_pol;
      logic [DBITS-1:0] d;
      logic [CBITS-1:0] ctrl;
   } uword_t;

   // CONT (4'd14) with the condition disabled; substituted for bad fetches
   localparam uword_t NOP_WORD = '{
      i: 4'd14, ccen_bar: 1'b1, cc_sel: 2'd0, cc_pol: 1'b0,
      d: '0, ctrl: '0
   };

   // Reset image of the pipeline register: I=0, condition disabled
   localparam uword_t RST_WORD = '{
      i: 4'd0, ccen_bar: 1'b1, cc_sel: 2'd0, cc_pol: 1'b0,
      d: '0, ctrl: '0
   };

   // ------------------------------------------------------------------
   // Control store
   // ------------------------------------------------------------------
   logic [SBITS-1:0]     store_q [DEPTH];
   logic [SBITS-1:0]     store_wr_word;
   logic [SBITS-1:0]     store_rd_word;
   logic [LOG_DEPTH-1:0] rd_idx;
   logic                 out_of_range;
   logic                 par_bad;
   logic                 fetch_bad;
   uword_t               fetch_word;

   // Build the word to be written, appending parity when enabled
   always_comb begin
`ifdef AM2910_UCODE_PARITY_EN
      store_wr_word = {bus.wr_data, (^bus.wr_data) ^ bus.wr_par_flip};
`else
      store_wr_word = bus.wr_data;
`endif
   end

   // Synchronous store write; the read below sees the pre-edge contents
   // NOTE: the store array has no reset branch -- resetting a RAM would force
   // it into flops and the contents must survive reset anyway.
   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         store_q[bus.wr_addr] <= store_wr_word;
      end
   end

   // Address decode, store read and bad-fetch substitution
   always_comb begin
      rd_idx        = bus.Y[LOG_DEPTH-1:0];
      out_of_range  = |(bus.Y >> LOG_DEPTH);
      store_rd_word = store_q[rd_idx];
`ifdef AM2910_UCODE_PARITY_EN
      // Even parity over data+parity bit must XOR to zero
      par_bad       = ~out_of_range & (^store_rd_word);
      fetch_word    = store_rd_word[SBITS-1:1];
`else
      par_bad       = 1'b0;
      fetch_word    = store_rd_word;
`endif
      fetch_bad     = out_of_range | par_bad;
      if (fetch_bad) begin
         fetch_word = NOP_WORD;
      end
   end

   // ------------------------------------------------------------------
   // Pipeline register and condition sample
   // ------------------------------------------------------------------
   uword_t     pipe_q,      pipe_d;
   logic [3:0] cond_q,      cond_d;
   logic       valid_q,     valid_d;
   logic       range_err_q, range_err_d;
`ifdef AM2910_UCODE_PARITY_EN
   logic       par_err_q,   par_err_d;
`endif

   // Next-state: fetch on every un-held edge, sticky error flags
   // NOTE: every output of this block gets a hold-value default first, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      pipe_d      = pipe_q;
      cond_d      = cond_q;
      valid_d     = valid_q;
      range_err_d = range_err_q;
`ifdef AM2910_UCODE_PARITY_EN
      par_err_d   = par_err_q;
`endif
      if (!bus.hold) begin
         pipe_d  = fetch_word;
         cond_d  = bus.cond;
         valid_d = 1'b1;
         if (out_of_range) begin
            range_err_d = 1'b1;
         end
`ifdef AM2910_UCODE_PARITY_EN
         if (par_bad) begin
            par_err_d = 1'b1;
         end
`endif
      end
   end

   // Pipeline state with asynchronous reset; the store is untouched by reset
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_q      <= RST_WORD;
         cond_q      <= 4'd0;
         valid_q     <= 1'b0;
         range_err_q <= 1'b0;
`ifdef AM2910_UCODE_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         pipe_q      <= pipe_d;
         cond_q      <= cond_d;
         valid_q     <= valid_d;
         range_err_q <= range_err_d;
`ifdef AM2910_UCODE_PARITY_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   // Output drive; CC_BAR uses only registered state, never bus.cond
   always_comb begin
      bus.I         = pipe_q.i;
      bus.CCEN_BAR  = pipe_q.ccen_bar;
      bus.D         = pipe_q.d;
      bus.ctrl      = pipe_q.ctrl;
      bus.CC_BAR    = ~(cond_q[pipe_q.cc_sel] ^ pipe_q.cc_pol);
      bus.valid     = valid_q;
      bus.range_err = range_err_q;
`ifdef AM2910_UCODE_PARITY_EN
      bus.par_err   = par_err_q;
`endif
   end

endmodule

// File: doc/am2910_ucode_pipe.md
# am2910_ucode_pipe

Microprogram control store and pipeline register sitting directly downstream of the am2910 microsequencer. Each cycle it takes the sequencer's next-address output Y, reads the addressed microword from an on-chip writable control store, and registers it into the pipeline register. The registered fields drive the sequencer's instruction (I), condition-enable (CCEN_BAR), branch data (D) and condition (CC_BAR) inputs, closing the classic 2910 fetch loop. The store is programmed through a separate write port.

## Interface
- ABITS, default 12: width of Y, the sequencer address.
- DBITS, default 12: width of the D branch/count field.
- LOG_DEPTH, default 6: control store holds 2^LOG_DEPTH words.
- CBITS, default 8: width of the free control field passed downstream.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- Y  in  ABITS  next microaddress from the sequencer.
- hold  in  1  freezes the pipeline register and condition sample.
- cond  in  4  raw status flags.
- wr_en  in  1  control store write strobe.
- wr_addr  in  LOG_DEPTH  write address.
- wr_data  in  16+DBITS+CBITS-8  microword, packed MSB→LSB as {I[3:0], CCEN_BAR, CC_SEL[1:0], CC_POL, D, CTRL}.
- I  out  4  registered instruction.
- CCEN_BAR  out  1  registered condition enable.
- CC_BAR  out  1  selected condition, active-low.
- D  out  DBITS  registered branch/count data.
- ctrl  out  CBITS  registered control field.
- valid  out  1  pipeline register holds a fetched word.
- range_err  out  1  sticky flag: Y addressed beyond the store.

## Operation
- Store: 2^LOG_DEPTH words. Not reset. Writes are synchronous on wr_en.
- Fetch: on each rising edge with hold=0:
  - pipe ← store[Y[LOG_DEPTH-1:0]];
  - cond_q ← cond;
  - valid ← 1.
- Out of range: if any bit of Y[ABITS-1:LOG_DEPTH] is set, pipe instead loads the NOP word {I=4'd14, CCEN_BAR=1, CC_SEL=0, CC_POL=0, D=0, CTRL=0}, and range_err sets. range_err clears only on reset.
- Condition: CC_BAR = ~(cond_q[CC_SEL] ^ CC_POL). This path is combinational from registered state only, with no combinational path from cond.
- Hold: pipe, cond_q, valid and range_err detection are all frozen. Store writes still proceed.
- Read/write collision (wr_addr equals the read index in the same edge): the fetch returns the old contents (read-before-write). The new word is visible on the next fetch.
- Mid-operation reset: all outputs return asynchronously to their reset values. The store keeps its contents.

## Timing
- Reset values: I=0, CCEN_BAR=1, D=0, ctrl=0, valid=0, range_err=0, cond_q=0 (so CC_BAR=1).
- Latency: Y sampled at edge n appears on I/D/ctrl/CCEN_BAR after edge n, and is consumed by the sequencer at edge n+1. cond sampled at edge n appears on CC_BAR after edge n.
- First edge after reset deassertion with hold=0 sets valid=1.
- A write at edge n is readable by a fetch at edge n+1.

## Configuration
- AM2910_UCODE_PARITY_EN defined:
  - Each store word carries an extra even-parity bit, computed from wr_data at write time.
  - An added input wr_par_flip (1 bit) inverts the stored parity bit for error injection.
  - An added output par_err (1 bit, sticky, reset 0) sets on a fetch whose parity mismatches.
  - On a mismatch the NOP word is loaded instead.
- AM2910_UCODE_PARITY_EN undefined: no parity storage, and neither wr_par_flip nor par_err exist.

## Test plan
- Reset check: assert reset mid-run with non-zero pipe → I=0, CCEN_BAR=1, CC_BAR=1, valid=0 immediately; store contents preserved (re-fetch of addr 3 returns the prior word).
- Fetch: write addr 5 with I=4'd3, D=12'h0A5, CC_SEL=2, CC_POL=0; Y=5 with cond=4'b0100 → next cycle I=3, D=0A5, CC_BAR=0; with cond=0 → CC_BAR=1.
- Hold: fetch addr 5, then hold=1 for 3 cycles while Y=7 → outputs unchanged; release → addr 7 word appears one edge later.
- Out of range: Y=12'h040 (DEPTH=64) → I=14, D=0, range_err=1; it stays 1 after valid in-range fetches.
- Collision: addr 9 holds A, write B to 9 on the same edge as Y=9 → output A; next fetch of 9 → B.
- Parity (macro on): write addr 2 with wr_par_flip=1, fetch 2 → par_err=1, I=14; a clean rewrite and refetch → word correct, par_err remains 1.
